cp0_irq: RTL

Parametrised coprocessor 0 for the multicycle/pipelined MIPS datapath. Supports up to seven external interrupt lines plus an internal Count/Compare timer, each selectable as level or edge-captured, with fixed priority and a Cause exception-code field identifying the winning line. It supplies `TakenInterrupt` and `EPC` to the PC-select logic and services `mfc0`/`mtc0`/`eret` exactly as the single-timer coprocessor did.

---
 rtl/cp0_irq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cp0_irq.sv
// Coprocessor 0 with NUM_IRQ external lines plus a Count/Compare timer.
// Each external line is level or edge-captured; Cause records the highest-priority winner.
module cp0_irq #(
  parameter int                 NUM_IRQ   = 1,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [4:0]         regnum,
  input  logic [31:0]        wr_data,
  input  logic [29:0]        next_pc,
  input  logic               MTC0,
  input  logic               ERET,
  output logic [31:0]        rd_data,
  output logic [29:0]        EPC,
  output logic               TakenInterrupt
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [31:0]        count;
  logic [31:0]        compare;
  logic [7:0]         im;
  logic               ie;
  logic               exl;
  logic               tp;
  logic [NUM_IRQ-1:0] edge_pend;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [2:0]         exc_code;
  logic [29:0]        epc_q;

  logic [7:0]         ip;
  logic [7:0]         pending;
  logic [2:0]         winner;
  logic               wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [NUM_IRQ-1:0] edge_rise;
  logic [NUM_IRQ-1:0] edge_clr;
  logic [NUM_IRQ-1:0] edge_pend_nxt;

  // Highest set request bit wins; the timer sits at bit 7.
  function automatic logic [2:0] prio_index(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (req[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  assign wr_count   = MTC0 && (regnum == REG_COUNT);
  assign wr_compare = MTC0 && (regnum == REG_COMPARE);
  assign wr_status  = MTC0 && (regnum == REG_STATUS);
  assign wr_cause   = MTC0 && (regnum == REG_CAUSE);
  assign wr_epc     = MTC0 && (regnum == REG_EPC);

  always_comb begin
    ip    = '0;
    ip[7] = tp;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ip[i] = EDGE_MASK[i] ? edge_pend[i] : irq[i];
    end
  end

  assign pending        = ip & im;
  assign winner         = prio_index(pending);
  assign TakenInterrupt = (|pending) & ie & ~exl;

  // A rising edge in the same cycle as a write-1-to-clear keeps the line pending.
  assign edge_rise     = irq & ~irq_prev & EDGE_MASK;
  assign edge_clr      = wr_data[8 +: NUM_IRQ] & {NUM_IRQ{wr_cause}};
  assign edge_pend_nxt = (edge_rise | (edge_pend & ~edge_clr)) & EDGE_MASK;

  always_comb begin
    rd_data = '0;
    case (regnum)
      REG_COUNT:   rd_data = count;
      REG_COMPARE: rd_data = compare;
      REG_STATUS:  rd_data = {16'b0, im, 6'b0, exl, ie};
      REG_CAUSE:   rd_data = {16'b0, ip, 3'b0, exc_code, 2'b0};
      REG_EPC:     rd_data = {epc_q, 2'b00};
      default:     rd_data = '0;
    endcase
  end

  assign EPC = epc_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count     <= '0;
      compare   <= '1;
      im        <= '0;
      ie        <= 1'b0;
      exl       <= 1'b0;
      tp        <= 1'b0;
      edge_pend <= '0;
      irq_prev  <= '0;
      exc_code  <= '0;
      epc_q     <= '0;
    end else begin
      count     <= wr_count ? wr_data : count + 32'd1;
      edge_pend <= edge_pend_nxt;
      irq_prev  <= irq;

      // Match uses the pre-increment Count; a Compare write clears and dominates.
      if (wr_compare) begin
        compare <= wr_data;
        tp      <= 1'b0;
      end else if (count == compare) begin
        tp <= 1'b1;
      end

      if (wr_status) begin
        im <= wr_data[15:8];
        ie <= wr_data[0];
      end

      if (TakenInterrupt) begin
        exl      <= 1'b1;
        exc_code <= winner;
        epc_q    <= next_pc;
      end else begin
        if (ERET)   exl   <= 1'b0;
        if (wr_epc) epc_q <= wr_data[31:2];
      end
    end
  end

endmodule
